mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore-FSM controller that sequences a shared-memory multicycle MIPS datapath (one memory port, ALU reused for PC+4 and branches).
//  Decodes op/funct: R-type add/sub/and/or/slt, lw, sw, beq, addi, j, plus the extension ops jaladd (R-type funct 000001) and sw+ (op 101111).
//  Waits on a memory-ready handshake and counts retired instructions.
// PARAMETERS
//  USE_MEMREADY  1   1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1)
//  EXT_OPS       1   1: jaladd/sw+ decoded; 0: they go to TRAP
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  op           in   6   instr[31:26] from instruction register
//  funct        in   6   instr[5:0]
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   memory completes read/write this cycle
//  pcen         out  1   PC load enable = pcwrite | (branch & zero)
//  iord         out  1   mem addr: 0=PC, 1=ALUOut
//  memwrite     out  1   memory write strobe
//  irwrite      out  1   instruction register load
//  regwrite     out  1   register file write
//  regdst       out  2   00 rt, 01 rd, 10 rs, 11 $31
//  wdsrc        out  2   RF write data: 00 ALUOut, 01 Data, 10 PC, 11 ALUResult
//  alusrca      out  1   0=PC, 1=A
//  alusrcb      out  2   00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  pcsrc        out  2   00 ALUResult, 01 ALUOut, 10 jump target
//  alucontrol   out  3   010 add, 110 sub, 000 and, 001 or, 111 slt
//  state        out  4   current state (debug)
//  trap         out  1   sticky illegal-instruction flag
//  retired      out  32  retired-instruction count
// BEHAVIOUR
//  States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5,
//   RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, JALADD 12, SWPWR 13, SWPWB 14, TRAP 15.
//  Reset (reset_n=0, async): state=FETCH, retired=0, trap=0; all enables forced 0; muxes 0; alucontrol=010.
//  Outputs are Moore-decoded from state, except pcen.
//  All enables are gated by reset_n, so nothing strobes while reset is held.
//  FETCH: iord0 alusrca0 alusrcb01 add pcsrc00 irwrite pcwrite; held until mem_ready, then DECODE.
//  DECODE: alusrca0 alusrcb11 add (branch target -> ALUOut). Next state by op:
//   lw/sw/sw+ -> MEMADR; R-type with legal funct -> RTEX; funct 000001 -> JALADD;
//   beq -> BEQEX; addi -> ADDIEX; j -> JEX; else -> TRAP.
//  MEMADR: alusrca1 alusrcb10 add. Then lw -> MEMRD, sw -> MEMWR, sw+ -> SWPWR.
//  MEMRD: iord1; wait mem_ready; then MEMWB.
//  MEMWB: regwrite, regdst00, wdsrc01.
//  MEMWR / SWPWR: iord1, memwrite held every cycle until mem_ready.
//   Then MEMWR -> FETCH; SWPWR -> SWPWB.
//  SWPWB: alusrca1 alusrcb01 add, regwrite regdst10 wdsrc11 (rs <= rs+4).
//  RTEX: alusrca1 alusrcb00, ALU op from funct. RTWB: regwrite regdst01 wdsrc00.
//  BEQEX: alusrca1 alusrcb00 sub, branch=1 pcsrc01; pcen=zero.
//  ADDIEX: alusrca1 alusrcb10 add. ADDIWB: regwrite regdst00 wdsrc00.
//  JEX: pcsrc10 pcwrite.
//  JALADD: alusrca1 alusrcb00 add, pcsrc00 pcwrite, regwrite regdst11 wdsrc10.
//   $31 <= PC (already PC+4); PC <= rs+rt, same edge.
//  Terminal states (MEMWB, MEMWR, RTWB, BEQEX, ADDIWB, JEX, JALADD, SWPWB): next state FETCH, retired += 1 (wraps at 2^32).
//  TRAP: all enables 0, trap=1, no exit except reset; retired frozen.
//  mem_ready is sampled only in FETCH/MEMRD/MEMWR/SWPWR and ignored elsewhere.
//  Reset mid-instruction aborts it immediately: no partial regwrite/memwrite, not counted.
// TESTING
//  addi 0x20040008, mem_ready=1 -> FETCH,DECODE,ADDIEX,ADDIWB (4 clk); ADDIWB: regwrite=1 regdst=00; retired 0->1.
//  jaladd 0x0085f801 -> JALADD at cycle 3: pcwrite, pcsrc=00, regwrite, regdst=11, wdsrc=10, alucontrol=010; retired+1.
//  sw+ 0xbc850000, mem_ready low 2 clk in SWPWR -> memwrite high 3 clk, then SWPWB regdst=10 wdsrc=11 alusrcb=01.
//  beq 0x10a60003 with zero=1 -> pcen=1 in BEQEX; repeated with zero=0 -> pcen=0; both retire.
//  op 6'b111111 -> TRAP after DECODE, trap=1, enables 0 for 20 clk; EXT_OPS=0 with sw+ -> TRAP.
//  reset_n low during MEMWR (mem_ready=0) -> memwrite drops same cycle, state=0, retired=0; release -> FETCH resumes.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: Moore FSM that sequences a shared-memory datapath
// (one memory port, ALU reused for PC+4 and branch targets), waits on a memory
// ready handshake, flags illegal instructions and counts retired instructions.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   op, funct           instruction fields from the instruction register
//   zero                ALU zero flag (only used for beq)
//   mem_ready           memory finishes the current read/write this cycle
//   pcen ... alucontrol datapath controls (decoded from state; pcen also uses zero)
//   state               current FSM state (debug)
//   trap                sticky illegal-instruction flag
//   retired             retired-instruction count (wraps)
module mips_multicycle_ctrl #(
    parameter bit USE_MEMREADY = 1'b1,
    parameter bit EXT_OPS      = 1'b1,
    localparam int unsigned OP_W  = 6,
    localparam int unsigned ST_W  = 4,
    localparam int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  op,
    input  logic [OP_W-1:0]  funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic [1:0]       regdst,
    output logic [1:0]       wdsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic [ST_W-1:0]  state,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11,
        S_JALADD = 4'd12, S_SWPWR  = 4'd13, S_SWPWB  = 4'd14, S_TRAP   = 4'd15
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_SWP   = 6'b101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD    = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB    = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND    = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR     = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT    = 6'b101010;
    localparam logic [OP_W-1:0] FN_JALADD = 6'b000001;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             trap_q, trap_d;
    logic             rdy;
    logic             rt_legal;
    logic             pcwrite;
    logic             branch;
    logic             retire;

    // With the handshake disabled every memory access completes in one cycle.
    assign rdy = USE_MEMREADY ? mem_ready : 1'b1;

    assign rt_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);

    // Next state, retire strobe and Moore control decode.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 2'b00;
        wdsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_SWP:       state_d = EXT_OPS ? S_MEMADR : S_TRAP;
                    OP_RTYPE: begin
                        if (rt_legal)                          state_d = S_RTEX;
                        else if (EXT_OPS && funct == FN_JALADD) state_d = S_JALADD;
                        else                                   state_d = S_TRAP;
                    end
                    OP_BEQ:  state_d = S_BEQEX;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JEX;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)                state_d = S_MEMRD;
                else if (op == OP_SW)           state_d = S_MEMWR;
                else if (EXT_OPS && op == OP_SWP) state_d = S_SWPWR;
                else                            state_d = S_TRAP;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                wdsrc    = 2'b01;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_RTEX: begin
                alusrca = 1'b1;
                case (funct)
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
                state_d = S_RTWB;
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JALADD: begin
                // PC already holds PC+4 here, so $31 takes the link while PC <= rs+rt.
                alusrca  = 1'b1;
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                regdst   = 2'b11;
                wdsrc    = 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_SWPWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (rdy) state_d = S_SWPWB;
            end
            S_SWPWB: begin
                // Post-increment of the base register: rs <= rs + 4.
                alusrca  = 1'b1;
                alusrcb  = 2'b01;
                regwrite = 1'b1;
                regdst   = 2'b10;
                wdsrc    = 2'b11;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Nothing strobes and all muxes park while reset is held.
        if (!reset_n) begin
            retire     = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            regdst     = 2'b00;
            wdsrc      = 2'b00;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            alucontrol = ALU_ADD;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    assign trap_d    = trap_q | (state_d == S_TRAP);

    // State, retire counter and sticky trap flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
        end
    end

    assign state   = state_q;
    assign trap    = trap_q;
    assign retired = retired_q;

endmodule
